// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-side bundle for the 7-segment scan driver.
// master: the datapath supplying BCD words and enable; slave: the driver.
interface bcd_7seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (output en, load, bcd_in,
                  input  seg, an, digit_idx, frame_done);
  modport slave  (input  en, load, bcd_in,
                  output seg, an, digit_idx, frame_done);
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD 7-segment driver.
// One digit per REFRESH_DIV-clock slot, double-buffered so a frame never
// mixes old and new values. Optional leading-zero blanking is compiled in
// with macro BCD7SEG_LZB_EN.

// Per-digit decoder: BCD to active-high {a..g}, codes 10..15 show a dash.
module bcd_7seg_digit (
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg_raw
);
  // Lookup with blanking override
  always_comb begin
    seg_raw = 7'h01;
    case (code)
      4'd0: seg_raw = 7'h7E;
      4'd1: seg_raw = 7'h30;
      4'd2: seg_raw = 7'h6D;
      4'd3: seg_raw = 7'h79;
      4'd4: seg_raw = 7'h33;
      4'd5: seg_raw = 7'h5B;
      4'd6: seg_raw = 7'h5F;
      4'd7: seg_raw = 7'h70;
      4'd8: seg_raw = 7'h7F;
      4'd9: seg_raw = 7'h7B;
      default: seg_raw = 7'h01;
    endcase
    if (blank) seg_raw = 7'h00;
  end
endmodule

module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_7seg_scan_driver_if.slave   bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = $clog2(REFRESH_DIV);

  logic [PW-1:0]                presc;
  logic [IDX_W-1:0]             digit_idx;
  logic                         frame_done;
  logic [4*NUM_DIGITS-1:0]      pend, disp;
  logic [6:0]                   seg_q;
  logic [NUM_DIGITS-1:0]        an_q;
  logic [NUM_DIGITS-1:0]        blank;
  logic [NUM_DIGITS-1:0][6:0]   seg_dig;
  logic                         tick, wrap;

  assign tick = bus.en && (presc == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef BCD7SEG_LZB_EN
  // A digit is blanked when it and every digit above it hold zero.
  logic [NUM_DIGITS-1:0] nz;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lzb
    assign nz[i] = |disp[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = ~|nz[NUM_DIGITS-1:i];
    end
  end
`else
  assign blank = '0;
`endif

  // Decode every digit in parallel; the scan index picks one.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_7seg_digit u_dig (
      .code    (disp[4*i +: 4]),
      .blank   (blank[i]),
      .seg_raw (seg_dig[i])
    );
  end

  // Refresh prescaler, digit scan index and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else if (!bus.en) begin
      presc      <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        presc     <= '0;
        digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Pending/display double buffer; a load on the swap cycle bypasses pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      disp <= '0;
    end else begin
      if (bus.load) pend <= bus.bcd_in;
      if (wrap || !bus.en) disp <= bus.load ? bus.bcd_in : pend;
    end
  end

  // Registered segment/anode outputs, one cycle behind digit_idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      an_q  <= '0;
    end else if (!bus.en) begin
      seg_q <= '0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_dig[digit_idx];
      an_q  <= NUM_DIGITS'(1) << digit_idx;
    end
  end

  assign bus.seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign bus.an         = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;
  assign bus.digit_idx  = digit_idx;
  assign bus.frame_done = frame_done;
endmodule
